// File: rtl/jelly2_rtos_pkg.sv
// ---------------------------------------------------------------------------
// jelly2_rtos_pkg
// Shared types for the RTOS semaphore stage.
//   sem_op_t    : command op codes accepted on cmd_op
//   sem_state_t : semaphore control FSM states
// Op code 2'b11 is POL when JELLY2_RTOS_SEMAPHORE_POL_EN is defined,
// otherwise it is CANCEL.
// ---------------------------------------------------------------------------
package jelly2_rtos_pkg;

  typedef enum logic [1:0] {
    SEM_NOP        = 2'd0,
    SEM_WAIT       = 2'd1,
    SEM_SIGNAL     = 2'd2,
    SEM_CANCEL_POL = 2'd3
  } sem_op_t;

  typedef enum logic {
    SEM_IDLE   = 1'b0,
    SEM_SETTLE = 1'b1
  } sem_state_t;

endpackage

// File: rtl/jelly2_rtos_semaphore.sv
// ---------------------------------------------------------------------------
// jelly2_rtos_semaphore
// Semaphore control stage in front of the RTOS wait-queue FIFO. Accepts one
// WAIT / SIGNAL / CANCEL (or POL) command per handshake, keeps the semaphore
// count, drives the FIFO add/remove strobes and pulses grants to the
// scheduler. All outputs except cmd_ready are registered.
//
// Optional feature macro: JELLY2_RTOS_SEMAPHORE_POL_EN
//   defined   : op 2'b11 is POL (non-blocking try-acquire, fail pulse if busy)
//   undefined : op 2'b11 is CANCEL
//
// Ports:
//   reset_n            async active-low reset
//   clk, cke           clock and clock enable (cke=0 holds every register)
//   cmd_op/id/valid    command in; cmd_ready high only in IDLE
//   acquire_id/valid   one-cycle grant pulse
//   fail_valid         one-cycle pulse: POL failure or SIGNAL at MAX_SEMCNT
//   semcnt             current count
//   que_add_*          FIFO push strobe
//   que_remove_*       FIFO remove-by-ID strobe
//   que_top_*          FIFO head, trusted only while IDLE
// ---------------------------------------------------------------------------
module jelly2_rtos_semaphore
  import jelly2_rtos_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int SEMCNT_WIDTH = 4,
  parameter int INIT_SEMCNT  = 0,
  parameter int MAX_SEMCNT   = 15
) (
  input  logic                    reset_n,
  input  logic                    clk,
  input  logic                    cke,

  input  sem_op_t                 cmd_op,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,

  output logic [ID_WIDTH-1:0]     acquire_id,
  output logic                    acquire_valid,
  output logic                    fail_valid,
  output logic [SEMCNT_WIDTH-1:0] semcnt,

  output logic [ID_WIDTH-1:0]     que_add_id,
  output logic                    que_add_valid,
  output logic [ID_WIDTH-1:0]     que_remove_id,
  output logic                    que_remove_valid,
  input  logic [ID_WIDTH-1:0]     que_top_id,
  input  logic                    que_top_valid
);

  localparam logic [SEMCNT_WIDTH-1:0] INIT_CNT = SEMCNT_WIDTH'(INIT_SEMCNT);
  localparam logic [SEMCNT_WIDTH-1:0] MAX_CNT  = SEMCNT_WIDTH'(MAX_SEMCNT);
  localparam logic [SEMCNT_WIDTH-1:0] ZERO_CNT = {SEMCNT_WIDTH{1'b0}};
  localparam logic [SEMCNT_WIDTH-1:0] ONE_CNT  = SEMCNT_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]     ZERO_ID  = {ID_WIDTH{1'b0}};

  sem_state_t                state_r,        state_s;
  logic [SEMCNT_WIDTH-1:0]   semcnt_r,       semcnt_s;
  logic [ID_WIDTH-1:0]       acq_id_r,       acq_id_s;
  logic                      acq_valid_r,    acq_valid_s;
  logic                      fail_valid_r,   fail_valid_s;
  logic [ID_WIDTH-1:0]       add_id_r,       add_id_s;
  logic                      add_valid_r,    add_valid_s;
  logic [ID_WIDTH-1:0]       rem_id_r,       rem_id_s;
  logic                      rem_valid_r,    rem_valid_s;

  // A count can be taken directly only if nobody is already queued ahead.
  logic                      can_take_s;

  assign can_take_s = (semcnt_r != ZERO_CNT) && !que_top_valid;
  assign cmd_ready  = (state_r == SEM_IDLE);

  // Next-state decode: pulses default low, IDs hold their last value.
  always_comb begin
    state_s      = state_r;
    semcnt_s     = semcnt_r;
    acq_id_s     = acq_id_r;
    acq_valid_s  = 1'b0;
    fail_valid_s = 1'b0;
    add_id_s     = add_id_r;
    add_valid_s  = 1'b0;
    rem_id_s     = rem_id_r;
    rem_valid_s  = 1'b0;

    if (state_r == SEM_SETTLE) begin
      // FIFO has absorbed the strobe on this edge; head is valid again.
      state_s = SEM_IDLE;
    end else if (cmd_valid) begin
      case (cmd_op)
        SEM_WAIT: begin
          if (can_take_s) begin
            semcnt_s    = semcnt_r - ONE_CNT;
            acq_id_s    = cmd_id;
            acq_valid_s = 1'b1;
          end else begin
            add_id_s    = cmd_id;
            add_valid_s = 1'b1;
            state_s     = SEM_SETTLE;
          end
        end
        SEM_SIGNAL: begin
          if (que_top_valid) begin
            // Hand the unit straight to the head waiter; count unchanged.
            rem_id_s    = que_top_id;
            rem_valid_s = 1'b1;
            acq_id_s    = que_top_id;
            acq_valid_s = 1'b1;
            state_s     = SEM_SETTLE;
          end else if (semcnt_r == MAX_CNT) begin
            fail_valid_s = 1'b1;
          end else begin
            semcnt_s = semcnt_r + ONE_CNT;
          end
        end
        SEM_CANCEL_POL: begin
`ifdef JELLY2_RTOS_SEMAPHORE_POL_EN
          if (can_take_s) begin
            semcnt_s    = semcnt_r - ONE_CNT;
            acq_id_s    = cmd_id;
            acq_valid_s = 1'b1;
          end else begin
            fail_valid_s = 1'b1;
          end
`else
          rem_id_s    = cmd_id;
          rem_valid_s = 1'b1;
          state_s     = SEM_SETTLE;
`endif
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; cke=0 freezes everything including pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= SEM_IDLE;
      semcnt_r     <= INIT_CNT;
      acq_id_r     <= ZERO_ID;
      acq_valid_r  <= 1'b0;
      fail_valid_r <= 1'b0;
      add_id_r     <= ZERO_ID;
      add_valid_r  <= 1'b0;
      rem_id_r     <= ZERO_ID;
      rem_valid_r  <= 1'b0;
    end else if (cke) begin
      state_r      <= state_s;
      semcnt_r     <= semcnt_s;
      acq_id_r     <= acq_id_s;
      acq_valid_r  <= acq_valid_s;
      fail_valid_r <= fail_valid_s;
      add_id_r     <= add_id_s;
      add_valid_r  <= add_valid_s;
      rem_id_r     <= rem_id_s;
      rem_valid_r  <= rem_valid_s;
    end else begin
      state_r      <= state_r;
    end
  end

  assign acquire_id       = acq_id_r;
  assign acquire_valid    = acq_valid_r;
  assign fail_valid       = fail_valid_r;
  assign semcnt           = semcnt_r;
  assign que_add_id       = add_id_r;
  assign que_add_valid    = add_valid_r;
  assign que_remove_id    = rem_id_r;
  assign que_remove_valid = rem_valid_r;

endmodule

// File: tb/tb_jelly2_rtos_semaphore.sv
// ---------------------------------------------------------------------------
// tb_jelly2_rtos_semaphore
// Self-checking bench: a directed vector table with hand-derived expectations,
// a randomized phase compared against a behavioural model (integer count plus
// a queue standing in for the wait FIFO), and a reset-during-SETTLE sequence.
// ---------------------------------------------------------------------------
module tb_jelly2_rtos_semaphore;
  import jelly2_rtos_pkg::*;

  localparam int INIT = 2;
  localparam int MAX  = 15;

  logic          reset_n;
  logic          clk;
  logic          cke;
  sem_op_t       cmd_op;
  logic [3:0]    cmd_id;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    acquire_id;
  logic          acquire_valid;
  logic          fail_valid;
  logic [3:0]    semcnt;
  logic [3:0]    que_add_id;
  logic          que_add_valid;
  logic [3:0]    que_remove_id;
  logic          que_remove_valid;
  logic [3:0]    que_top_id;
  logic          que_top_valid;

  jelly2_rtos_semaphore #(
    .ID_WIDTH(4), .SEMCNT_WIDTH(4), .INIT_SEMCNT(INIT), .MAX_SEMCNT(MAX)
  ) dut (
    .reset_n(reset_n), .clk(clk), .cke(cke),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .acquire_id(acquire_id), .acquire_valid(acquire_valid), .fail_valid(fail_valid),
    .semcnt(semcnt),
    .que_add_id(que_add_id), .que_add_valid(que_add_valid),
    .que_remove_id(que_remove_id), .que_remove_valid(que_remove_valid),
    .que_top_id(que_top_id), .que_top_valid(que_top_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Wait-queue contents as seen by the FIFO (task IDs, head at index 0).
  int q[$];

  // Reference model state.
  int   m_cnt;
  bit   m_busy;      // a queue op is in flight, next cycle is not accepting
  logic e_acq, e_fail, e_add, e_rem;
  int   e_acq_id, e_add_id, e_rem_id;

  typedef struct {
    logic       cke;
    logic       valid;
    sem_op_t    op;
    logic [3:0] id;
    logic       acq;
    logic [3:0] acq_id;
    logic       fail;
    logic       add;
    logic [3:0] add_id;
    logic       rem;
    logic [3:0] rem_id;
    logic [3:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t vec[$];

  function automatic void row(logic c, logic v, sem_op_t op, logic [3:0] id,
                              logic acq, logic [3:0] acq_id, logic fail,
                              logic add, logic [3:0] add_id,
                              logic rem, logic [3:0] rem_id,
                              logic [3:0] cnt, logic rdy);
    vec_t r;
    r.cke = c; r.valid = v; r.op = op; r.id = id;
    r.acq = acq; r.acq_id = acq_id; r.fail = fail;
    r.add = add; r.add_id = add_id; r.rem = rem; r.rem_id = rem_id;
    r.cnt = cnt; r.rdy = rdy;
    vec.push_back(r);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare(input logic acq, input int acq_id, input logic fail,
                         input logic add, input int add_id,
                         input logic rem, input int rem_id,
                         input int cnt, input logic rdy);
    chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
    chk("semcnt", 32'(semcnt), 32'(cnt));
    chk("acquire_valid", 32'(acquire_valid), 32'(acq));
    chk("fail_valid", 32'(fail_valid), 32'(fail));
    chk("que_add_valid", 32'(que_add_valid), 32'(add));
    chk("que_remove_valid", 32'(que_remove_valid), 32'(rem));
    chk("add_remove_exclusive", 32'(que_add_valid & que_remove_valid), 32'd0);
    if (acq) chk("acquire_id", 32'(acquire_id), acq_id);
    if (add) chk("que_add_id", 32'(que_add_id), add_id);
    if (rem) chk("que_remove_id", 32'(que_remove_id), rem_id);
  endtask

  task automatic drive_top();
    que_top_valid = (q.size() > 0);
    que_top_id    = (q.size() > 0) ? 4'(q[0]) : 4'd0;
  endtask

  // Model: what the block should present after the next enabled edge.
  task automatic predict(input logic c, input logic v, input sem_op_t op, input int id);
    if (!c) return;
    e_acq = 1'b0; e_fail = 1'b0; e_add = 1'b0; e_rem = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
      return;
    end
    if (!v) return;
    case (op)
      SEM_WAIT: begin
        if (m_cnt > 0 && q.size() == 0) begin
          m_cnt--; e_acq = 1'b1; e_acq_id = id;
        end else begin
          e_add = 1'b1; e_add_id = id; m_busy = 1'b1;
        end
      end
      SEM_SIGNAL: begin
        if (q.size() > 0) begin
          e_rem = 1'b1; e_rem_id = q[0]; e_acq = 1'b1; e_acq_id = q[0]; m_busy = 1'b1;
        end else if (m_cnt == MAX) begin
          e_fail = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      SEM_CANCEL_POL: begin
`ifdef JELLY2_RTOS_SEMAPHORE_POL_EN
        if (m_cnt > 0 && q.size() == 0) begin
          m_cnt--; e_acq = 1'b1; e_acq_id = id;
        end else begin
          e_fail = 1'b1;
        end
`else
        e_rem = 1'b1; e_rem_id = id; m_busy = 1'b1;
`endif
      end
      default: ;
    endcase
  endtask

  // One clock: advance model, let the FIFO absorb strobes, sample at edge+1.
  task automatic step();
    logic       c_pre, add_pre, rem_pre;
    logic [3:0] add_id_pre, rem_id_pre;
    predict(cke, cmd_valid, cmd_op, 32'(cmd_id));
    c_pre = cke;
    add_pre = que_add_valid; add_id_pre = que_add_id;
    rem_pre = que_remove_valid; rem_id_pre = que_remove_id;
    @(posedge clk);
    if (c_pre) begin
      if (add_pre) begin
        q.push_back(int'(add_id_pre));
      end else if (rem_pre) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i] == int'(rem_id_pre)) begin
            q.delete(i);
            break;
          end
        end
      end
    end
    drive_top();
    #1;
  endtask

  task automatic full_reset();
    reset_n = 1'b0; cke = 1'b1; cmd_valid = 1'b0; cmd_op = SEM_NOP; cmd_id = 4'd0;
    q.delete(); drive_top();
    m_cnt = INIT; m_busy = 1'b0;
    e_acq = 1'b0; e_fail = 1'b0; e_add = 1'b0; e_rem = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    full_reset();
    // Reset state, including zeroed IDs.
    compare(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, INIT, 1'b1);
    chk("reset_acquire_id", 32'(acquire_id), 32'd0);
    chk("reset_add_id", 32'(que_add_id), 32'd0);
    chk("reset_remove_id", 32'(que_remove_id), 32'd0);

    // Directed table (count starts at 2, queue empty).
    row(1,1,SEM_WAIT,3,   1,3, 0, 0,0, 0,0, 1, 1);
    row(1,1,SEM_WAIT,5,   1,5, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_WAIT,7,   0,0, 0, 1,7, 0,0, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_SIGNAL,0, 1,7, 0, 0,0, 1,7, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
`ifdef JELLY2_RTOS_SEMAPHORE_POL_EN
    row(1,1,SEM_CANCEL_POL,1, 0,0, 1, 0,0, 0,0, 0, 1);
`else
    row(1,1,SEM_CANCEL_POL,1, 0,0, 0, 0,0, 1,1, 0, 0);
    row(1,0,SEM_NOP,0,        0,0, 0, 0,0, 0,0, 0, 1);
`endif
    row(1,1,SEM_WAIT,2,   0,0, 0, 1,2, 0,0, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_WAIT,4,   0,0, 0, 1,4, 0,0, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_WAIT,6,   0,0, 0, 1,6, 0,0, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
`ifdef JELLY2_RTOS_SEMAPHORE_POL_EN
    row(1,1,SEM_CANCEL_POL,4, 0,0, 1, 0,0, 0,0, 0, 1);
    row(1,1,SEM_SIGNAL,0, 1,2, 0, 0,0, 1,2, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_SIGNAL,0, 1,4, 0, 0,0, 1,4, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
`else
    row(1,1,SEM_CANCEL_POL,4, 0,0, 0, 0,0, 1,4, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_SIGNAL,0, 1,2, 0, 0,0, 1,2, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
`endif
    row(1,1,SEM_SIGNAL,0, 1,6, 0, 0,0, 1,6, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    // Clock enable held low during SETTLE: everything frozen.
    row(1,1,SEM_WAIT,9,   0,0, 0, 1,9, 0,0, 0, 0);
    row(0,1,SEM_WAIT,9,   0,0, 0, 1,9, 0,0, 0, 0);
    row(0,1,SEM_WAIT,9,   0,0, 0, 1,9, 0,0, 0, 0);
    row(0,1,SEM_WAIT,9,   0,0, 0, 1,9, 0,0, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    row(1,1,SEM_SIGNAL,0, 1,9, 0, 0,0, 1,9, 0, 0);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 0, 1);
    // Count up to the ceiling, then one more SIGNAL saturates with fail.
    for (int k = 1; k <= MAX; k++)
      row(1,1,SEM_SIGNAL,0, 0,0, 0, 0,0, 0,0, 4'(k), 1);
    row(1,1,SEM_SIGNAL,0, 0,0, 1, 0,0, 0,0, 4'(MAX), 1);
    row(1,0,SEM_NOP,0,    0,0, 0, 0,0, 0,0, 4'(MAX), 1);

    foreach (vec[i]) begin
      cke = vec[i].cke; cmd_valid = vec[i].valid; cmd_op = vec[i].op; cmd_id = vec[i].id;
      step();
      compare(vec[i].acq, int'(vec[i].acq_id), vec[i].fail, vec[i].add, int'(vec[i].add_id),
              vec[i].rem, int'(vec[i].rem_id), int'(vec[i].cnt), vec[i].rdy);
    end

    // Randomized traffic against the model; commands stay stable while busy.
    for (int n = 0; n < 800; n++) begin
      cke = ($urandom_range(0, 7) != 0);
      if (!m_busy) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_op    = sem_op_t'(2'($urandom_range(0, 3)));
        cmd_id    = 4'($urandom_range(0, 15));
      end
      step();
      compare(e_acq, e_acq_id, e_fail, e_add, e_add_id, e_rem, e_rem_id, m_cnt, !m_busy);
    end

    // Reset asserted in the middle of a SETTLE cycle.
    full_reset();
    cmd_valid = 1'b1; cmd_op = SEM_WAIT;
    cmd_id = 4'd1; step();
    cmd_id = 4'd2; step();
    cmd_id = 4'd3; step();
    compare(1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 0, 0, 1'b0);
    cmd_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    compare(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, INIT, 1'b1);
    full_reset();
    cmd_valid = 1'b1; cmd_op = SEM_WAIT; cmd_id = 4'd12;
    step();
    compare(1'b1, 12, 1'b0, 1'b0, 0, 1'b0, 0, INIT - 1, 1'b1);
    cmd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jelly2_rtos_semaphore.md
Name: jelly2_rtos_semaphore

Overview:
- Semaphore control stage sitting directly upstream of the RTOS wait-queue FIFO, and consuming its top entry.
- Accepts one task command per handshake: WAIT, SIGNAL, CANCEL, or POL when enabled.
- Maintains the semaphore count and drives the FIFO add/remove strobes.
- Issues one-cycle wakeup/acquire pulses to the task scheduler.

Parameters:
- ID_WIDTH, 4, task ID width; must match the FIFO.
- SEMCNT_WIDTH, 4, width of the semaphore counter.
- INIT_SEMCNT, 0, counter value after reset.
- MAX_SEMCNT, 15, saturation limit; must be ≤ 2**SEMCNT_WIDTH-1.

Ports:
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clk  in  1  the single clock.
- cke  in  1  clock enable; when 0 all state, including output pulses, is held.
- cmd_op  in  2  sem_op_t: NOP / WAIT / SIGNAL / CANCEL(-or-POL, see Optional Feature).
- cmd_id  in  ID_WIDTH  issuing/target task ID.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high when the FSM is in IDLE (combinational from state).
- acquire_id  out  ID_WIDTH  task granted the semaphore.
- acquire_valid  out  1  one-cycle grant pulse.
- fail_valid  out  1  one-cycle pulse: POL failure or SIGNAL overflow.
- semcnt  out  SEMCNT_WIDTH  current counter value.
- que_add_id / que_add_valid  out  ID_WIDTH / 1  FIFO add strobe.
- que_remove_id / que_remove_valid  out  ID_WIDTH / 1  FIFO remove strobe.
- que_top_id / que_top_valid  in  ID_WIDTH / 1  FIFO head.

Behaviour:
- Reset values:
  - state=IDLE, so cmd_ready=1.
  - semcnt=INIT_SEMCNT.
  - All *_valid outputs 0; ID outputs 0.
- Integration: the FIFO's synchronous reset is driven from ~reset_n.
- Acceptance: a command is accepted at an edge with cke & cmd_valid & cmd_ready. All outputs are registered and appear the cycle after acceptance.
- Pulse rule: pulses last exactly one cke-qualified cycle.
- FSM states are IDLE and SETTLE.
  - IDLE → SETTLE on any command that touches the queue.
  - SETTLE → IDLE unconditionally after one cycle, with cmd_ready=0 during SETTLE.
  - Purpose: the FIFO updates on the edge ending the strobe cycle, so que_top_* is only trusted in IDLE.
  - Throughput: queue ops run one per 2 cycles; counter-only ops run one per cycle.
- WAIT:
  - If semcnt>0 and !que_top_valid: semcnt-1, acquire_id=cmd_id, acquire pulse; stay in IDLE.
  - Otherwise: que_add pulse with cmd_id; go to SETTLE.
- SIGNAL:
  - If que_top_valid: que_remove pulse with que_top_id, plus an acquire pulse with the same ID in the same cycle; semcnt unchanged; go to SETTLE.
  - Else if semcnt==MAX_SEMCNT: fail pulse; semcnt unchanged.
  - Else: semcnt+1.
- CANCEL: que_remove pulse with cmd_id; go to SETTLE; semcnt unchanged. An ID that is absent from the queue is harmless.
- NOP: accepted with no effect.
- que_add_valid and que_remove_valid are never high in the same cycle; the FIFO gives add priority, so this rule is mandatory.
- cmd_* is don't-care when cmd_valid=0. A command held while cmd_ready=0 must be held stable by the source.
- Reset asserted mid-SETTLE: immediate return to IDLE; strobes cleared asynchronously.
- Arithmetic is unsigned and never wraps, at either 0 or MAX.

Optional Feature:
- Macro: JELLY2_RTOS_SEMAPHORE_POL_EN.
- Defined: op code 2'b11 is POL.
  - If semcnt>0 and !que_top_valid: semcnt-1 and acquire pulse with cmd_id.
  - Else: fail pulse.
  - Never queues; stays in IDLE.
- Undefined: 2'b11 is decoded as CANCEL and no POL logic is generated.

Decomposition:
- Package jelly2_rtos_pkg holds:
  - typedef enum logic[1:0] sem_op_t {SEM_NOP=0, SEM_WAIT=1, SEM_SIGNAL=2, SEM_CANCEL_POL=3};
  - typedef enum logic sem_state_t {SEM_IDLE, SEM_SETTLE}.
- No sub-module; the FIFO is instantiated beside this block by the parent, not inside it.

Test Plan:
- Reset with INIT_SEMCNT=2, then WAIT id3, then WAIT id5 → acquire pulses id3 then id5 on consecutive cycles, semcnt 2→1→0, no que strobes.
- semcnt=0: WAIT id7 → que_add id7 one cycle later, cmd_ready low for 1 cycle. Then SIGNAL → que_remove id7 and acquire id7 in the same cycle; semcnt stays 0.
- semcnt=15, queue empty: SIGNAL → fail pulse; semcnt stays 15. With queue empty and semcnt=14: SIGNAL → semcnt=15, no fail.
- Queue holds 2,4,6: CANCEL id4, then SIGNAL → que_remove id4, then que_remove id2 with acquire id2. que_add_valid and que_remove_valid are never concurrent.
- cke=0 for 3 cycles during SETTLE → state, strobes, and semcnt frozen; resumes correctly. reset_n pulsed low mid-SETTLE → all strobes 0 immediately, semcnt=INIT_SEMCNT, cmd_ready=1.
- POL_EN defined: semcnt=0, POL id1 → fail pulse, no que_add. Undefined: op 3 id1 → que_remove id1.
